// File: rtl/seq_divider_if.sv
// seq_divider_if: start/busy/done handshake bundle for the sequential divider.
//   start        - request a division (honoured only while the divider is idle)
//   dividend     - unsigned dividend, captured on an accepted start
//   divisor      - unsigned divisor, captured on an accepted start
//   busy         - divider is working (or presenting its result)
//   done         - one-cycle pulse, results valid
//   quotient     - division result, held until the next accepted start
//   remainder    - division result, held until the next accepted start
//   div_by_zero  - captured divisor was zero, held until the next accepted start
// master: the requester side; slave: the divider side.
interface seq_divider_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: restoring shift-subtract divider, one SHIFT or SUBTRACT step
// per clock over a single working register r = {a[WIDTH:0], q[WIDTH-1:0]}.
// A WIDTH-bit division takes 2*WIDTH steps and is followed by a one-cycle
// DONE state that pulses done.
//   clk    - rising-edge clock
//   reset  - asynchronous active-high reset; aborts any division in flight
//   bus    - handshake/operand/result bundle (slave side of seq_divider_if)
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        SUBTRACT,
        DONE
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [2*WIDTH:0]   r;
    logic [WIDTH-1:0]   divisor_q;
    logic [CW-1:0]      count;
    logic               div_by_zero_q;

    logic [WIDTH:0]     a;
    logic [WIDTH+1:0]   trial;
    logic               borrow;

    assign a      = r[2*WIDTH:WIDTH];
    // One extra bit beyond A so the MSB of the difference is the borrow.
    assign trial  = {1'b0, a} - {2'b00, divisor_q};
    assign borrow = trial[WIDTH+1];

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    next_state = (bus.divisor == '0) ? DONE : SHIFT;
                end
            end
            SHIFT:    next_state = SUBTRACT;
            SUBTRACT: next_state = (count == CW'(1)) ? DONE : SHIFT;
            DONE:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r             <= '0;
            divisor_q     <= '0;
            count         <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        divisor_q     <= bus.divisor;
                        count         <= CW'(WIDTH);
                        div_by_zero_q <= (bus.divisor == '0);
                        if (bus.divisor == '0) begin
                            // Skip the iterations: preload the fixed
                            // divide-by-zero answer, quotient all ones and
                            // remainder equal to the dividend.
                            r <= {1'b0, bus.dividend, {WIDTH{1'b1}}};
                        end else begin
                            r <= {{(WIDTH+1){1'b0}}, bus.dividend};
                        end
                    end
                end
                SHIFT: begin
                    r <= {r[2*WIDTH-1:0], 1'b0};
                end
                SUBTRACT: begin
                    // On borrow the register is left alone (restore step);
                    // the quotient bit shifted in as 0 is already correct.
                    if (!borrow) begin
                        r <= {trial[WIDTH:0], r[WIDTH-1:1], 1'b1};
                    end
                    count <= count - CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);
    assign bus.quotient    = r[WIDTH-1:0];
    assign bus.remainder   = r[2*WIDTH-1:WIDTH];
    assign bus.div_by_zero = div_by_zero_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed bench for seq_divider (WIDTH=4). Expected results
// are computed from the operands and queued when a division is launched,
// then popped and compared when done pulses.
module tb_seq_divider;
    localparam int W   = 4;
    localparam int LAT = 2 * W;

    logic clk = 1'b0;
    logic reset;

    seq_divider_if #(.WIDTH(W)) bus_if ();

    seq_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"}, 32'(bus_if.busy), 0);
        check({tag, "_done"}, 32'(bus_if.done), 0);
        check({tag, "_quot"}, 32'(bus_if.quotient), 0);
        check({tag, "_rem"},  32'(bus_if.remainder), 0);
        check({tag, "_dbz"},  32'(bus_if.div_by_zero), 0);
    endtask

    // Queue the expected result, then present one start pulse accepted at
    // the next rising edge (E0). Operands are scrambled afterwards so the
    // design must rely on its captured copies.
    task automatic launch(input int dividend, input int divisor);
        exp_t e;
        if (divisor == 0) begin
            e.q   = '1;
            e.r   = W'(dividend);
            e.dbz = 1'b1;
            e.lat = 0;
        end else begin
            e.q   = W'(dividend / divisor);
            e.r   = W'(dividend % divisor);
            e.dbz = 1'b0;
            e.lat = LAT;
        end
        sb.push_back(e);
        @(negedge clk);
        bus_if.start    = 1'b1;
        bus_if.dividend = W'(dividend);
        bus_if.divisor  = W'(divisor);
        @(posedge clk);
        #1;
        bus_if.start    = 1'b0;
        bus_if.dividend = ~W'(dividend);
        bus_if.divisor  = ~W'(divisor);
    endtask

    // Count edges after E0 until done; optionally raise a competing start
    // while the divider is busy.
    task automatic wait_result(input string tag, input bit glitch);
        int   lat = 0;
        exp_t e;
        @(negedge clk);
        check({tag, "_busy"}, 32'(bus_if.busy), 1);
        while (!bus_if.done && lat < 40) begin
            if (glitch && lat == 3) begin
                bus_if.start    = 1'b1;
                bus_if.dividend = 4'd15;
                bus_if.divisor  = 4'd1;
            end
            if (glitch && lat == 5) bus_if.start = 1'b0;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (sb.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        check({tag, "_latency"}, 32'(lat), 32'(e.lat));
        check({tag, "_quot"},    32'(bus_if.quotient), 32'(e.q));
        check({tag, "_rem"},     32'(bus_if.remainder), 32'(e.r));
        check({tag, "_dbz"},     32'(bus_if.div_by_zero), 32'(e.dbz));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(bus_if.done), 0);
        check({tag, "_idle"},       32'(bus_if.busy), 0);
        repeat (2) @(negedge clk);
        check({tag, "_quot_held"}, 32'(bus_if.quotient), 32'(e.q));
        check({tag, "_rem_held"},  32'(bus_if.remainder), 32'(e.r));
    endtask

    initial begin
        bit saw_done;
        reset           = 1'b1;
        bus_if.start    = 1'b0;
        bus_if.dividend = '0;
        bus_if.divisor  = '0;

        @(negedge clk);
        check_idle_zero("in_reset");
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check_idle_zero("after_reset");

        launch(9, 2);   wait_result("9_2", 1'b0);
        launch(15, 4);  wait_result("15_4", 1'b0);
        launch(7, 9);   wait_result("7_9", 1'b0);
        launch(15, 1);  wait_result("15_1", 1'b0);
        launch(13, 0);  wait_result("13_0", 1'b0);

        // Start raised while busy must be ignored.
        launch(9, 2);   wait_result("ignore_busy_start", 1'b1);
        launch(15, 4);  wait_result("after_ignore", 1'b0);
        launch(13, 0);  wait_result("13_0_again", 1'b0);
        launch(15, 4);  wait_result("dbz_cleared", 1'b0);

        // Abort during the SUBTRACT step of the second iteration.
        launch(9, 2);
        repeat (4) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check_idle_zero("async_reset");
        sb.delete();
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus_if.done) saw_done = 1'b1;
        end
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (bus_if.done) saw_done = 1'b1;
        end
        check("abort_no_done", 32'(saw_done), 0);
        check("abort_idle", 32'(bus_if.busy), 0);

        launch(9, 2);   wait_result("after_abort", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
